// File: rtl/vip_gaussian_filter_3x3.sv
// 3x3 Gaussian smoothing stage (1-2-1 / 2-4-2 / 1-2-1, divide by 16) with 3-clk fixed latency.
// Optional macro GAUSS_ROUND_EN selects round-half-up (with clamp) instead of truncation.
module vip_gaussian_filter_3x3 #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned CNT_W     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       matrix_frame_vsync,
  input  logic       matrix_frame_href,
  input  logic       matrix_frame_hsync,
  input  logic [7:0] matrix_p11,
  input  logic [7:0] matrix_p12,
  input  logic [7:0] matrix_p13,
  input  logic [7:0] matrix_p21,
  input  logic [7:0] matrix_p22,
  input  logic [7:0] matrix_p23,
  input  logic [7:0] matrix_p31,
  input  logic [7:0] matrix_p32,
  input  logic [7:0] matrix_p33,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_hsync,
  output logic [7:0] post_img_Y
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned SUM_W  = 12;
  localparam int unsigned SYNC_W = 3;
  localparam int unsigned LAT    = 3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MIN  = CNT_W'(2);

  // Position tracking
  logic             r_href_d;
  logic             r_vsync_d;
  logic             r_frame_valid;
  logic [CNT_W-1:0] r_col_cnt;
  logic [CNT_W-1:0] r_row_cnt;

  logic w_href_fall;
  logic w_vsync_rise;
  logic w_border;

  // Pipeline
  logic [ROW_W-1:0] r_r1;
  logic [ROW_W-1:0] r_r2;
  logic [ROW_W-1:0] r_r3;
  logic [PIX_W-1:0] r_ctr_s1;
  logic             r_border_s1;

  logic [SUM_W-1:0] r_sum;
  logic [PIX_W-1:0] r_ctr_s2;
  logic             r_border_s2;

  logic [LAT-1:0][SYNC_W-1:0] r_sync_sr;
  logic [PIX_W-1:0]           r_y;
  logic [PIX_W-1:0]           w_y_filt;
  logic                       w_href_s2;

  function automatic logic [ROW_W-1:0] row_sum(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b,
    input logic [PIX_W-1:0] c
  );
    row_sum = ROW_W'(a) + {1'b0, b, 1'b0} + ROW_W'(c);
  endfunction

  assign w_href_fall  = r_href_d & ~matrix_frame_href;
  assign w_vsync_rise = matrix_frame_vsync & ~r_vsync_d;

  // Row counts are untrusted until a vsync has been seen since reset
  assign w_border = ~r_frame_valid
                  | (r_row_cnt < ROW_MIN)
                  | (r_col_cnt == '0)
                  | (r_col_cnt >= COL_LAST);

  // Edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_href_d  <= matrix_frame_href;
      r_vsync_d <= matrix_frame_vsync;
    end
  end

  // Column counter: index of the pixel currently presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
    end else if (!matrix_frame_href) begin
      r_col_cnt <= '0;
    end else if (r_col_cnt != CNT_MAX) begin
      r_col_cnt <= r_col_cnt + CNT_W'(1);
    end
  end

  // Row counter: vsync clear takes priority over an href falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
    end else if (w_vsync_rise) begin
      r_row_cnt <= '0;
    end else if (w_href_fall && (r_row_cnt != CNT_MAX)) begin
      r_row_cnt <= r_row_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
    end else if (w_vsync_rise) begin
      r_frame_valid <= 1'b1;
    end
  end

  // Stage 1: horizontal 1-2-1 per row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r1        <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_ctr_s1    <= '0;
      r_border_s1 <= 1'b0;
    end else begin
      r_r1        <= row_sum(matrix_p11, matrix_p12, matrix_p13);
      r_r2        <= row_sum(matrix_p21, matrix_p22, matrix_p23);
      r_r3        <= row_sum(matrix_p31, matrix_p32, matrix_p33);
      r_ctr_s1    <= matrix_p22;
      r_border_s1 <= w_border;
    end
  end

  // Stage 2: vertical 1-2-1 across rows; 4080 max fits 12 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_ctr_s2    <= '0;
      r_border_s2 <= 1'b0;
    end else begin
      r_sum       <= SUM_W'(r_r1) + {1'b0, r_r2, 1'b0} + SUM_W'(r_r3);
      r_ctr_s2    <= r_ctr_s1;
      r_border_s2 <= r_border_s1;
    end
  end

`ifdef GAUSS_ROUND_EN
  localparam int unsigned RND_W = SUM_W + 1;

  logic [RND_W-1:0] w_sum_rnd;
  logic [RND_W-1:0] w_sum_q;

  // Round half up; clamp kept for safety even though 4080+8 stays in range
  assign w_sum_rnd = RND_W'(r_sum) + RND_W'(8);
  assign w_sum_q   = w_sum_rnd >> 4;
  assign w_y_filt  = (w_sum_q > RND_W'(255)) ? 8'hFF : w_sum_q[PIX_W-1:0];
`else
  logic w_unused_sum_lsb;

  assign w_unused_sum_lsb = ^r_sum[3:0];
  assign w_y_filt         = r_sum[SUM_W-1:4];
`endif

  assign w_href_s2 = r_sync_sr[1][1];

  // Stage 3: blank outside href, passthrough on border, else filtered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else if (!w_href_s2) begin
      r_y <= '0;
    end else if (r_border_s2) begin
      r_y <= r_ctr_s2;
    end else begin
      r_y <= w_y_filt;
    end
  end

  // Sync delay line {vsync, href, hsync}, aligned with the pixel pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_sr <= '0;
    end else begin
      r_sync_sr <= {r_sync_sr[LAT-2:0],
                    {matrix_frame_vsync, matrix_frame_href, matrix_frame_hsync}};
    end
  end

  assign post_frame_vsync = r_sync_sr[LAT-1][2];
  assign post_frame_href  = r_sync_sr[LAT-1][1];
  assign post_frame_hsync = r_sync_sr[LAT-1][0];
  assign post_img_Y       = r_y;

endmodule

// File: tb/tb_vip_gaussian_filter_3x3.sv
// Directed bench for vip_gaussian_filter_3x3: hand-computed pixels checked 3 clk after drive.
module tb_vip_gaussian_filter_3x3;

  localparam int IMG_W = 640;
`ifdef GAUSS_ROUND_EN
  localparam int IMP = 64;
`else
  localparam int IMP = 63;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs, hr, hs;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic       post_frame_vsync, post_frame_href, post_frame_hsync;
  logic [7:0] post_img_Y;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // {vsync, href, hsync, y} expected, index 2 is due at the current edge
  logic [10:0] exq [3];

  always #5 clk = ~clk;

  vip_gaussian_filter_3x3 dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matrix_frame_vsync (vs),
    .matrix_frame_href  (hr),
    .matrix_frame_hsync (hs),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33),
    .post_frame_vsync   (post_frame_vsync),
    .post_frame_href    (post_frame_href),
    .post_frame_hsync   (post_frame_hsync),
    .post_img_Y         (post_img_Y)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_win(input logic [7:0] c, input logic [7:0] o);
    p11 = o; p12 = o; p13 = o;
    p21 = o; p22 = c; p23 = o;
    p31 = o; p32 = o; p33 = o;
  endtask

  task automatic step(input logic v, input logic h, input logic s, input int y);
    vs = v; hr = h; hs = s;
    @(posedge clk);
    #1;
    exq[2] = exq[1];
    exq[1] = exq[0];
    exq[0] = {v, h, s, 8'(y)};
    check_eq($sformatf("vsync@%0d", cyc), int'(post_frame_vsync), int'(exq[2][10]));
    check_eq($sformatf("href@%0d", cyc),  int'(post_frame_href),  int'(exq[2][9]));
    check_eq($sformatf("hsync@%0d", cyc), int'(post_frame_hsync), int'(exq[2][8]));
    check_eq($sformatf("y@%0d", cyc),     int'(post_img_Y),       int'(exq[2][7:0]));
    cyc++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    vs = 1'b0; hr = 1'b0; hs = 1'b0;
    set_win(8'd0, 8'd0);
    for (int i = 0; i < 3; i++) exq[i] = '0;
    #12;
    check_eq("rst_vsync", int'(post_frame_vsync), 0);
    check_eq("rst_href",  int'(post_frame_href),  0);
    check_eq("rst_hsync", int'(post_frame_hsync), 0);
    check_eq("rst_y",     int'(post_img_Y),       0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(3);

    // Flat frame: every position yields 100 whether filtered or passed through
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      set_win(8'd100, 8'd100);
      for (int c = 0; c < IMG_W; c++) step(1'b0, 1'b1, 1'b0, 100);
      gap(4);
    end

    // Rows 0 and 1 are border: centre 37 passes through
    vsync_pulse();
    for (int l = 0; l < 2; l++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      set_win(8'd37, 8'd200);
      for (int c = 0; c < IMG_W; c++) step(1'b0, 1'b1, 1'b0, 37);
      gap(4);
    end

    // Row 2: filtered interior, column borders, over-long line
    step(1'b0, 1'b0, 1'b1, 0);
    for (int c = 0; c < IMG_W + 4; c++) begin
      int e;
      if (c == 0 || c >= IMG_W - 1) begin
        set_win(8'd37, 8'd200); e = 37;
      end else if (c == 1) begin
        set_win(8'd255, 8'd0); e = IMP;
      end else if (c == 2) begin
        set_win(8'd255, 8'd255); e = 255;
      end else if (c == 3) begin
        set_win(8'd100, 8'd100); e = 100;
      end else if (c == 4) begin
        p11 = 8'd10; p12 = 8'd20; p13 = 8'd30;
        p21 = 8'd40; p22 = 8'd50; p23 = 8'd60;
        p31 = 8'd70; p32 = 8'd80; p33 = 8'd90;
        e = 50;
      end else begin
        set_win(8'(c), 8'(c)); e = c % 256;
      end
      step(1'b0, 1'b1, 1'b0, e);
    end
    gap(4);

    // Row 3 with an href gap: pixel after the gap is a left border again
    step(1'b0, 1'b0, 1'b1, 0);
    set_win(8'd255, 8'd0);
    step(1'b0, 1'b1, 1'b0, 255);
    for (int c = 1; c < 5; c++) step(1'b0, 1'b1, 1'b0, IMP);
    gap(2);
    step(1'b0, 1'b1, 1'b0, 255);
    step(1'b0, 1'b1, 1'b0, IMP);
    step(1'b0, 1'b1, 1'b0, IMP);

    // vsync rise in the same cycle as href fall: row clears to 0
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 255);
    gap(4);

    // Mid-line reset clears all outputs asynchronously
    vsync_pulse();
    step(1'b0, 1'b0, 1'b1, 0);
    set_win(8'd100, 8'd100);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 1'b0, 100);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vsync", int'(post_frame_vsync), 0);
    check_eq("mid_rst_href",  int'(post_frame_href),  0);
    check_eq("mid_rst_hsync", int'(post_frame_hsync), 0);
    check_eq("mid_rst_y",     int'(post_img_Y),       0);
    for (int i = 0; i < 3; i++) exq[i] = '0;
    set_win(8'd0, 8'd0);
    gap(3);
    rst_n = 1'b1;
    gap(2);

    // After new vsync: two passthrough lines, third line filtered
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      set_win(8'd255, 8'd0);
      for (int c = 0; c < 6; c++)
        step(1'b0, 1'b1, 1'b0, (l < 2 || c == 0) ? 255 : IMP);
      gap(4);
    end
    gap(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
